// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the stall-injecting memory responder.
// Also holds the LFSR step function, so every stall generator uses the same sequence.
package mem_resp_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic  valid;
    logic  err;
    data_t data;
  } resp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stall_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when enabled.
// Intended as a pseudo-random stall source for any responder.
module stall_lfsr
  import mem_resp_pkg::*;
#(
  parameter logic [15:0] Seed = LFSR_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Seed;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/mem_stall_responder.sv
// Word-addressed memory responder with LFSR-driven grant stalls.
// Every accept produces one response a fixed number of cycles later.
module mem_stall_responder
  import mem_resp_pkg::*;
#(
  parameter int          AddrWidth   = 64,
  parameter int          DataWidth   = 64,
  parameter int          NumWords    = 1024,
  parameter int          ReadLatency = 2,
  parameter bit          StallEnable = 1'b1,
  parameter logic [15:0] LfsrSeed    = LFSR_SEED
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int IdxW  = $clog2(NumWords);
  localparam int StrbW = DataWidth / 8;

  logic [15:0]          lfsr;
  logic                 stall, accept, oor;
  logic [AddrWidth-4:0] idx;
  logic [IdxW-1:0]      widx;
  logic                 unused_bits;

  logic [DataWidth-1:0] mem_q [NumWords];
  resp_t                pipe_d [ReadLatency];
  resp_t                pipe_q [ReadLatency];
  logic [31:0]          stall_cnt_d, stall_cnt_q;

  // LFSR steps on every requesting cycle, granted or not
  stall_lfsr #(.Seed(LfsrSeed)) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (req_i),
    .state_o(lfsr)
  );

  assign stall       = StallEnable && (lfsr[1:0] == 2'b00);
  assign gnt_o       = req_i & ~stall & ~rst_i;
  assign accept      = req_i & gnt_o;
  assign idx         = addr_i[AddrWidth-1:3];
  assign oor         = idx >= (AddrWidth-3)'(NumWords);
  assign widx        = idx[IdxW-1:0];
  assign unused_bits = ^{addr_i[2:0], lfsr[15:2]};

  // Write commits at the accept edge, so a read on the next cycle sees it
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !oor) begin
      for (int b = 0; b < StrbW; b++) begin
        if (strb_i[b]) mem_q[widx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    pipe_d[0]       = '0;
    pipe_d[0].valid = accept;
    pipe_d[0].err   = accept & oor;
    if (accept && !we_i && !oor) pipe_d[0].data = mem_q[widx];
    for (int i = 1; i < ReadLatency; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_i && !gnt_o && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign rvalid_o    = pipe_q[ReadLatency-1].valid;
  assign err_o       = pipe_q[ReadLatency-1].err;
  assign rdata_o     = pipe_q[ReadLatency-1].data;
  assign stall_cnt_o = stall_cnt_q;

  // A stalled initiator must keep its request unchanged until granted
  property p_req_hold;
    @(posedge clk_i) disable iff (rst_i)
      (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                             $stable(wdata_i) && $stable(strb_i));
  endproperty
  a_req_hold: assert property (p_req_hold);

endmodule

// File: tb/tb_mem_stall_responder.sv
// Two responders (no stalls / LFSR stalls) share one request stream; a
// reference model predicts grants, stall counts and the ordered response stream.
module tb_mem_stall_responder;
  import mem_resp_pkg::*;

  localparam int NW  = 1024;
  localparam int RL0 = 2;
  localparam int RL1 = 3;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  strb = '0;

  logic        gnt [2], rvalid [2], err [2];
  logic [63:0] rdata [2];
  logic [31:0] scnt [2];

  always #5 clk = ~clk;

  mem_stall_responder #(.NumWords(NW), .ReadLatency(RL0), .StallEnable(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[0]), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .stall_cnt_o(scnt[0]));

  mem_stall_responder #(.NumWords(NW), .ReadLatency(RL1), .StallEnable(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[1]), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .stall_cnt_o(scnt[1]));

  int vectors = 0, miscompares = 0, cyc = 0;
  bit active = 1'b0;

  typedef struct {
    int          due;
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic [15:0] mlfsr [2];
  int          mcnt [2];
  logic [63:0] mmem [2][0:32];
  exp_t        q0 [$];
  exp_t        q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rl(input int k);
    return (k == 0) ? RL0 : RL1;
  endfunction

  function automatic bit mstall(input int k);
    return (k == 1) && (mlfsr[k][1:0] == 2'b00);
  endfunction

  function automatic bit q_due(input int k);
    if (k == 0) return q0.size() > 0 && q0[0].due == cyc;
    return q1.size() > 0 && q1[0].due == cyc;
  endfunction

  function automatic exp_t q_pop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference model: evaluates each clock edge from the request rules
  initial begin : model
    exp_t            e;
    longint unsigned w;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          mlfsr[k] = 16'hACE1;
          mcnt[k]  = 0;
          if (k == 0) q0.delete(); else q1.delete();
        end else if (req) begin
          if (mstall(k)) begin
            mcnt[k]++;
          end else begin
            w      = addr >> 3;
            e.due  = cyc + rl(k);
            e.err  = 1'b0;
            e.data = '0;
            if (w >= NW) e.err = 1'b1;
            else if (we) begin
              for (int b = 0; b < 8; b++)
                if (strb[b]) mmem[k][int'(w)][b*8 +: 8] = wdata[b*8 +: 8];
            end else e.data = mmem[k][int'(w)];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
          end
          mlfsr[k] = {mlfsr[k][14:0], mlfsr[k][15] ^ mlfsr[k][13] ^ mlfsr[k][12] ^ mlfsr[k][10]};
        end
      end
      if (rst) active = 1'b1;
      cyc++;
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model
  initial begin : monitor
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      if (active) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("gnt%0d", k), gnt[k], req & ~rst & ~mstall(k));
          check($sformatf("stall_cnt%0d", k), scnt[k], mcnt[k]);
          have = q_due(k);
          check($sformatf("rvalid%0d", k), rvalid[k], have);
          if (have) begin
            e = q_pop(k);
            if (rvalid[k]) begin
              check($sformatf("err%0d", k), err[k], e.err);
              check($sformatf("rdata%0d", k), rdata[k], e.data);
            end
          end else if (!rvalid[k]) begin
            check($sformatf("idle_err%0d", k), err[k], 1'b0);
            check($sformatf("idle_rdata%0d", k), rdata[k], 64'h0);
          end
        end
      end
    end
  end

  // Issue one request and hold it until the stalling responder grants it
  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s);
    int n = 0;
    bit g;
    req = 1'b1; we = w; addr = a; wdata = d; strb = s;
    do begin
      @(negedge clk);
      g = gnt[1];
      @(posedge clk);
      #1;
      n++;
    end while (!g && n < 64);
    if (!g) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: got no grant expected grant within 64 cycles (addr %h)", a);
    end
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [63:0] a;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // full write, read back, partial overwrite, read back
    do_req(1'b1, 64'h100, 64'h1122334455667788, 8'hFF);
    do_req(1'b0, 64'h100, 64'h0, 8'h00);
    do_req(1'b1, 64'h100, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    do_req(1'b0, 64'h100, 64'h0, 8'h00);
    idle(4);

    for (int i = 0; i < 32; i++) do_req(1'b1, 64'(i) << 3, {$urandom, $urandom}, 8'hFF);
    do_req(1'b0, 64'h0, 64'h0, 8'h00);
    do_req(1'b0, 64'h8, 64'h0, 8'h00);
    do_req(1'b0, 64'h10, 64'h0, 8'h00);
    idle(4);

    // out-of-range read/write must not alias onto word 0
    do_req(1'b0, 64'h2000, 64'h0, 8'h00);
    do_req(1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_req(1'b0, 64'h0, 64'h0, 8'h00);
    do_req(1'b1, 64'h2005, 64'h0, 8'h01);
    idle(4);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
      case ($urandom_range(0, 19))
        0:       a = 64'h2000 | (64'($urandom_range(0, 255)) << 3);
        1:       a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        default: a = (64'($urandom_range(0, 32)) << 3) | 64'($urandom_range(0, 7));
      endcase
      do_req(1'($urandom_range(0, 2) == 0), a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end
    idle(6);

    // reset while a read is in flight: its response must vanish
    do_req(1'b0, 64'h18, 64'h0, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("lfsr_seed0", u0.u_lfsr.state_o, 16'hACE1);
    check("lfsr_seed1", u1.u_lfsr.state_o, 16'hACE1);
    idle(8);
    check("q0_drained", 64'(q0.size()), 64'h0);
    check("q1_drained", 64'(q1.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
